// File: rtl/airlock_scheduler_if.sv
// rtl/airlock_scheduler_if.sv - requester/status bundle between airlock users and the scheduler
interface airlock_scheduler_if;
    logic OuterReq;
    logic InnerReq;
    logic OuterGnt;
    logic InnerGnt;
    logic OuterOpen;
    logic InnerOpen;
    logic PumpOut;
    logic PumpIn;
    logic EVState;
    logic Busy;

    modport master (
        output OuterReq, InnerReq,
        input  OuterGnt, InnerGnt, OuterOpen, InnerOpen, PumpOut, PumpIn, EVState, Busy
    );

    modport slave (
        input  OuterReq, InnerReq,
        output OuterGnt, InnerGnt, OuterOpen, InnerOpen, PumpOut, PumpIn, EVState, Busy
    );
endinterface

// File: rtl/airlock_scheduler.sv
// rtl/airlock_scheduler.sv - two-door airlock arbiter with pump sequencing and door interlock
module airlock_scheduler #(
    parameter int PUMP_CYCLES = 8,
    parameter int DOOR_CYCLES = 4
) (
    input  logic                  Clock,
    input  logic                  Reset,
    airlock_scheduler_if.slave    bus
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_PUMP    = 3'd1;
    localparam logic [2:0] S_OPENING = 3'd2;
    localparam logic [2:0] S_OPEN    = 3'd3;
    localparam logic [2:0] S_CLOSING = 3'd4;

    // Side encoding doubles as the chamber condition that side needs (outer = evacuated).
    localparam logic SIDE_INNER = 1'b0;
    localparam logic SIDE_OUTER = 1'b1;

    localparam logic [7:0] PUMP_LOAD = 8'(PUMP_CYCLES - 1);
    localparam logic [7:0] DOOR_LOAD = 8'(DOOR_CYCLES - 1);

    logic [2:0] r_state;
    logic       r_side;
    logic       r_ev;
    logic       r_last;
    logic [7:0] r_cnt;
    logic       r_outer_gnt;
    logic       r_inner_gnt;
    logic       r_outer_open;
    logic       r_inner_open;
    logic       r_pump_out;
    logic       r_pump_in;
    logic       r_busy;

    logic [2:0] w_nxt_state;
    logic       w_nxt_side;
    logic       w_nxt_ev;
    logic       w_nxt_last;
    logic [7:0] w_nxt_cnt;
    logic       w_req;
    logic       w_busy_n;
    logic       w_door_n;
    logic       w_pump_n;

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_side  = r_side;
        w_nxt_ev    = r_ev;
        w_nxt_last  = r_last;
        w_nxt_cnt   = r_cnt;
        w_req       = (r_side == SIDE_OUTER) ? bus.OuterReq : bus.InnerReq;

        case (r_state)
            S_IDLE: begin
                if (bus.OuterReq || bus.InnerReq) begin
                    if (bus.OuterReq && bus.InnerReq) begin
                        w_nxt_side = ~r_last;
                    end else begin
                        w_nxt_side = bus.OuterReq ? SIDE_OUTER : SIDE_INNER;
                    end
                    if (r_ev == w_nxt_side) begin
                        w_nxt_state = S_OPENING;
                        w_nxt_cnt   = DOOR_LOAD;
                    end else begin
                        w_nxt_state = S_PUMP;
                        w_nxt_cnt   = PUMP_LOAD;
                    end
                end
            end
            S_PUMP: begin
                if (r_cnt == 8'd0) begin
                    w_nxt_ev = ~r_ev;
                    if (w_req) begin
                        w_nxt_state = S_OPENING;
                        w_nxt_cnt   = DOOR_LOAD;
                    end else begin
                        // Requester walked away: chamber stays conditioned, doors never move.
                        w_nxt_state = S_IDLE;
                        w_nxt_last  = r_side;
                    end
                end else begin
                    w_nxt_cnt = r_cnt - 8'd1;
                end
            end
            S_OPENING: begin
                if (r_cnt == 8'd0) begin
                    w_nxt_state = S_OPEN;
                end else begin
                    w_nxt_cnt = r_cnt - 8'd1;
                end
            end
            S_OPEN: begin
                if (!w_req) begin
                    w_nxt_state = S_CLOSING;
                    w_nxt_cnt   = DOOR_LOAD;
                end
            end
            S_CLOSING: begin
                if (r_cnt == 8'd0) begin
                    w_nxt_state = S_IDLE;
                    w_nxt_last  = r_side;
                end else begin
                    w_nxt_cnt = r_cnt - 8'd1;
                end
            end
            default: begin
                w_nxt_state = S_IDLE;
                w_nxt_cnt   = 8'd0;
            end
        endcase
    end

    assign w_busy_n = (w_nxt_state != S_IDLE);
    assign w_pump_n = (w_nxt_state == S_PUMP);
    assign w_door_n = (w_nxt_state == S_OPENING) || (w_nxt_state == S_OPEN) ||
                      (w_nxt_state == S_CLOSING);

    // Outputs are registered from the next-state decode so they line up with the state edge.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            r_state      <= S_IDLE;
            r_side       <= SIDE_INNER;
            r_ev         <= 1'b0;
            r_last       <= SIDE_INNER;
            r_cnt        <= 8'd0;
            r_outer_gnt  <= 1'b0;
            r_inner_gnt  <= 1'b0;
            r_outer_open <= 1'b0;
            r_inner_open <= 1'b0;
            r_pump_out   <= 1'b0;
            r_pump_in    <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_nxt_state;
            r_side       <= w_nxt_side;
            r_ev         <= w_nxt_ev;
            r_last       <= w_nxt_last;
            r_cnt        <= w_nxt_cnt;
            r_outer_gnt  <= w_busy_n && (w_nxt_side == SIDE_OUTER);
            r_inner_gnt  <= w_busy_n && (w_nxt_side == SIDE_INNER);
            r_outer_open <= w_door_n && (w_nxt_side == SIDE_OUTER);
            r_inner_open <= w_door_n && (w_nxt_side == SIDE_INNER);
            r_pump_out   <= w_pump_n && (w_nxt_side == SIDE_OUTER);
            r_pump_in    <= w_pump_n && (w_nxt_side == SIDE_INNER);
            r_busy       <= w_busy_n;
        end
    end

    assign bus.OuterGnt  = r_outer_gnt;
    assign bus.InnerGnt  = r_inner_gnt;
    assign bus.OuterOpen = r_outer_open;
    assign bus.InnerOpen = r_inner_open;
    assign bus.PumpOut   = r_pump_out;
    assign bus.PumpIn    = r_pump_in;
    assign bus.EVState   = r_ev;
    assign bus.Busy      = r_busy;
endmodule

// File: tb/tb_airlock_scheduler.sv
// tb/tb_airlock_scheduler.sv - randomized and directed bench for airlock_scheduler
module tb_airlock_scheduler;
    localparam int P = 8;
    localparam int D = 4;

    logic Clock;
    logic Reset;
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 0;

    airlock_scheduler_if bus();

    airlock_scheduler #(.PUMP_CYCLES(P), .DOOR_CYCLES(D)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    // Service-timeline model: a service is a pump window of m_pl cycles followed by a door window.
    bit   m_active = 0;
    logic m_side   = 1'b0;
    logic m_ev     = 1'b0;
    logic m_last   = 1'b0;
    int   m_pl     = 0;
    int   m_k      = 0;
    int   m_close  = -1;

    always @(posedge Clock) begin
        logic req;
        bit   done;
        if (!Reset) begin
            m_active = 0; m_side = 1'b0; m_ev = 1'b0; m_last = 1'b0;
            m_pl = 0; m_k = 0; m_close = -1;
        end else if (!m_active) begin
            if (bus.OuterReq || bus.InnerReq) begin
                if (bus.OuterReq && bus.InnerReq) m_side = !m_last;
                else m_side = bus.OuterReq;
                m_pl = (m_ev != m_side) ? P : 0;
                m_k = 0; m_close = -1; m_active = 1;
            end
        end else begin
            req  = m_side ? bus.OuterReq : bus.InnerReq;
            done = 0;
            if (m_k < m_pl) begin
                if (m_k == m_pl - 1) begin
                    m_ev = !m_ev;
                    if (!req) done = 1;
                end
            end else if (m_k - m_pl < D) begin
                done = 0;
            end else if (m_close < 0) begin
                if (!req) m_close = m_k + 1;
            end else if (m_k - m_close == D - 1) begin
                done = 1;
            end
            if (done) begin
                m_active = 0;
                m_last = m_side;
            end else begin
                m_k++;
            end
        end
    end

    function automatic logic [7:0] dut_vec();
        return {bus.OuterGnt, bus.InnerGnt, bus.OuterOpen, bus.InnerOpen,
                bus.PumpOut, bus.PumpIn, bus.EVState, bus.Busy};
    endfunction

    always @(negedge Clock) begin
        logic [7:0] exp_v;
        logic [7:0] act_v;
        bit pumping, door, bad;
        if (mon_en) begin
            pumping = m_active && (m_k < m_pl);
            door    = m_active && !pumping;
            exp_v = {m_active && m_side, m_active && !m_side, door && m_side, door && !m_side,
                     pumping && m_side, pumping && !m_side, m_ev, m_active};
            act_v = dut_vec();
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL model_outputs t=%0t got %b want %b (OG IG OO IO PO PI EV BUSY)",
                         $time, act_v, exp_v);
            end
            bad = (bus.OuterOpen && bus.InnerOpen) || (bus.PumpIn && bus.PumpOut) ||
                  ((bus.PumpIn || bus.PumpOut) && (bus.OuterOpen || bus.InnerOpen)) ||
                  (bus.OuterOpen && !bus.EVState) || (bus.InnerOpen && bus.EVState) ||
                  (bus.OuterGnt && bus.InnerGnt);
            checks++;
            if (bad !== 1'b0) begin
                errors++;
                $display("FAIL interlock t=%0t got %b want no violation", $time, act_v);
            end
        end
    end

    task automatic do_reset();
        Reset = 1'b0;
        bus.OuterReq = 1'b0;
        bus.InnerReq = 1'b0;
        @(negedge Clock);
        Reset = 1'b1;
        @(negedge Clock);
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        bus.OuterReq = 1'($urandom_range(0, 1));
        bus.InnerReq = 1'b1;
        repeat (2) @(negedge Clock);
        checks++;
        if (dut_vec() !== 8'b0) begin
            errors++;
            $display("FAIL reset_outputs got %b want 00000000", dut_vec());
        end
        bus.OuterReq = 1'b0;
        bus.InnerReq = 1'b0;
        Reset = 1'b1;
        @(negedge Clock);
        checks++;
        if (bus.Busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle_noreq got %b want 0", bus.Busy);
        end
    endtask

    task automatic test_inner_basic();
        int  n;
        bit  saw_pump;
        do_reset();
        bus.InnerReq = 1'b1;
        @(negedge Clock);
        checks++;
        if ({bus.InnerGnt, bus.InnerOpen, bus.OuterGnt, bus.PumpIn, bus.PumpOut} !== 5'b11000) begin
            errors++;
            $display("FAIL inner_first_edge got %b want 11000",
                     {bus.InnerGnt, bus.InnerOpen, bus.OuterGnt, bus.PumpIn, bus.PumpOut});
        end
        saw_pump = 0;
        repeat (7) begin
            @(negedge Clock);
            if (bus.PumpIn || bus.PumpOut) saw_pump = 1;
        end
        bus.InnerReq = 1'b0;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge Clock);
            if (bus.PumpIn || bus.PumpOut) saw_pump = 1;
            if (bus.InnerOpen) n++;
            else break;
        end
        checks++;
        if (n != D) begin
            errors++;
            $display("FAIL inner_closing_len got %0d want %0d", n, D);
        end
        checks++;
        if ({bus.InnerGnt, bus.Busy, bus.EVState, saw_pump} !== 4'b0000) begin
            errors++;
            $display("FAIL inner_end_state got %b want 0000",
                     {bus.InnerGnt, bus.Busy, bus.EVState, saw_pump});
        end
    endtask

    task automatic test_outer_pump();
        int n;
        bit overlap;
        do_reset();
        bus.OuterReq = 1'b1;
        n = 0;
        overlap = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge Clock);
            if (bus.PumpOut) begin
                n++;
                if (bus.OuterOpen || !bus.OuterGnt) overlap = 1;
            end else break;
        end
        checks++;
        if (n != P || overlap) begin
            errors++;
            $display("FAIL outer_pump_len got %0d (overlap %0d) want %0d", n, overlap, P);
        end
        checks++;
        if ({bus.OuterOpen, bus.EVState, bus.OuterGnt} !== 3'b111) begin
            errors++;
            $display("FAIL outer_open_at_pump_exit got %b want 111",
                     {bus.OuterOpen, bus.EVState, bus.OuterGnt});
        end
        // Dropping the request mid-opening must not shorten the door travel.
        bus.OuterReq = 1'b0;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge Clock);
            if (bus.OuterOpen) n++;
            else break;
        end
        checks++;
        if (n != 2 * D) begin
            errors++;
            $display("FAIL outer_open_window got %0d want %0d", n, 2 * D);
        end
        checks++;
        if ({bus.EVState, bus.Busy} !== 2'b10) begin
            errors++;
            $display("FAIL outer_end_state got %b want 10", {bus.EVState, bus.Busy});
        end
    endtask

    task automatic test_both_arbitration();
        int  n;
        bit  hit;
        do_reset();
        bus.OuterReq = 1'b1;
        bus.InnerReq = 1'b1;
        @(negedge Clock);
        checks++;
        if ({bus.OuterGnt, bus.InnerGnt, bus.PumpOut} !== 3'b101) begin
            errors++;
            $display("FAIL both_first_grant got %b want 101",
                     {bus.OuterGnt, bus.InnerGnt, bus.PumpOut});
        end
        for (int i = 0; i < 40; i++) begin
            @(negedge Clock);
            if (bus.OuterOpen) break;
        end
        repeat (D) @(negedge Clock);
        bus.OuterReq = 1'b0;
        hit = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge Clock);
            if (!bus.OuterGnt) begin hit = 1; break; end
        end
        checks++;
        if ({hit, bus.InnerGnt, bus.Busy} !== 3'b100) begin
            errors++;
            $display("FAIL both_idle_gap got %b want 100", {hit, bus.InnerGnt, bus.Busy});
        end
        @(negedge Clock);
        checks++;
        if ({bus.InnerGnt, bus.PumpIn} !== 2'b11) begin
            errors++;
            $display("FAIL both_second_grant got %b want 11", {bus.InnerGnt, bus.PumpIn});
        end
        n = 1;
        for (int i = 0; i < 40; i++) begin
            @(negedge Clock);
            if (bus.PumpIn) n++;
            else break;
        end
        checks++;
        if (n != P || {bus.InnerOpen, bus.EVState} !== 2'b10) begin
            errors++;
            $display("FAIL both_pumpin got %0d open/ev %b want %0d 10",
                     n, {bus.InnerOpen, bus.EVState}, P);
        end
        bus.InnerReq = 1'b0;
        repeat (3 * D + 2) @(negedge Clock);
    endtask

    task automatic test_pulse_abort();
        int np, no;
        do_reset();
        bus.OuterReq = 1'b1;
        np = 0;
        no = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge Clock);
            if (i == 1) bus.OuterReq = 1'b0;
            if (bus.PumpOut) np++;
            if (bus.OuterOpen) no++;
        end
        checks++;
        if (np != P || no != 0) begin
            errors++;
            $display("FAIL pulse_pump got pump %0d open %0d want %0d 0", np, no, P);
        end
        checks++;
        if ({bus.EVState, bus.Busy, bus.OuterGnt} !== 3'b100) begin
            errors++;
            $display("FAIL pulse_end_state got %b want 100",
                     {bus.EVState, bus.Busy, bus.OuterGnt});
        end
    endtask

    task automatic test_reset_midway();
        bit opened;
        do_reset();
        bus.OuterReq = 1'b1;
        repeat (5) @(negedge Clock);
        Reset = 1'b0;
        @(negedge Clock);
        checks++;
        if (dut_vec() !== 8'b0) begin
            errors++;
            $display("FAIL reset_mid_pump got %b want 00000000", dut_vec());
        end
        Reset = 1'b1;
        bus.OuterReq = 1'b0;
        opened = 0;
        repeat (3) begin
            @(negedge Clock);
            if (bus.OuterOpen || bus.InnerOpen || bus.Busy) opened = 1;
        end
        checks++;
        if (opened) begin
            errors++;
            $display("FAIL reset_mid_pump_after got activity 1 want 0");
        end
        bus.InnerReq = 1'b1;
        repeat (8) @(negedge Clock);
        checks++;
        if (bus.InnerOpen !== 1'b1) begin
            errors++;
            $display("FAIL open_before_reset got %b want 1", bus.InnerOpen);
        end
        Reset = 1'b0;
        @(negedge Clock);
        checks++;
        if (dut_vec() !== 8'b0) begin
            errors++;
            $display("FAIL reset_mid_open got %b want 00000000", dut_vec());
        end
        Reset = 1'b1;
        bus.InnerReq = 1'b0;
        repeat (3) @(negedge Clock);
    endtask

    task automatic test_random();
        int bad;
        do_reset();
        bad = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge Clock);
            checks++;
            if (bus.Busy !== (bus.OuterGnt | bus.InnerGnt)) begin
                errors++;
                $display("FAIL random_busy_gnt cycle %0d got busy %b want %b",
                         i, bus.Busy, bus.OuterGnt | bus.InnerGnt);
            end
            if ($urandom_range(0, 7) == 0) bus.OuterReq = ~bus.OuterReq;
            if ($urandom_range(0, 7) == 0) bus.InnerReq = ~bus.InnerReq;
            Reset = ($urandom_range(0, 299) != 0);
        end
        Reset = 1'b1;
        bus.OuterReq = 1'b0;
        bus.InnerReq = 1'b0;
        repeat (2 * P + 4 * D) @(negedge Clock);
    endtask

    initial begin
        Reset = 1'b0;
        bus.OuterReq = 1'b0;
        bus.InnerReq = 1'b0;
        @(negedge Clock);
        mon_en = 1;
        test_reset();
        test_inner_basic();
        test_outer_pump();
        test_both_arbitration();
        test_pulse_abort();
        test_reset_midway();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
